// File: rtl/sync_ram_pkg.sv
// Shared constants and helpers for the dual-port RAM slice.
package sync_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sync_ram_dp_if.sv
// Write/read port bundle of sync_ram_dp; master drives requests, slave returns read data.
interface sync_ram_dp_if
  import sync_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [be_w(DATA_W)-1:0]   wr_be;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DATA_W-1:0]         rd_data;
  logic                      rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/sync_ram_out_stage.sv
// Optional output register for rd_data/rd_valid; adds one cycle of read latency.
module sync_ram_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              vld_in,
  output logic [DATA_W-1:0] data_out,
  output logic              vld_out
);

  // Stage p1: data only advances on a completed read so the output holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_out  <= 1'b0;
      data_out <= '0;
    end else begin
      vld_out <= vld_in;
      if (vld_in) data_out <= data_in;
    end
  end

endmodule

// File: rtl/sync_ram_dp.sv
// Simple dual-port synchronous RAM: byte-enabled write port, read port with
// selectable read-during-write policy and optional output register.
module sync_ram_dp
  import sync_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUT_REG  = 0
) (
  input logic           clk,
  input logic           rst,
  sync_ram_dp_if.slave  bus
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DATA_W % 8 != 0) begin : g_err_width
      $error("sync_ram_dp: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_err_depth
      $error("sync_ram_dp: DEPTH must be in 1..2**ADDR_W");
    end
  endgenerate

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              rd_ok;
  logic              hit;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_next;

  // Out-of-range reads return zero; a same-address hit may bypass the merged word
  always_comb begin
    wr_ok   = bus.wr_en && in_range(bus.wr_addr);
    rd_ok   = in_range(bus.rd_addr);
    hit     = wr_ok && (bus.wr_addr == bus.rd_addr);
    rd_word = mem[bus.rd_addr[IDX_W-1:0]];
    merged  = rd_word;
    for (int i = 0; i < BE_W; i++) begin
      if (bus.wr_be[i]) merged[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
    rd_next = '0;
    if (rd_ok) rd_next = (RDW_MODE == RDW_WRITE_FIRST && hit) ? merged : rd_word;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.wr_be[i]) mem[bus.wr_addr[IDX_W-1:0]][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;

  // Stage p0: array read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= bus.rd_en;
      if (bus.rd_en) data_p0 <= rd_next;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] data_p1;
      logic              vld_p1;

      sync_ram_out_stage #(.DATA_W(DATA_W)) u_out_stage (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_p0),
        .vld_in   (vld_p0),
        .data_out (data_p1),
        .vld_out  (vld_p1)
      );

      assign bus.rd_data  = data_p1;
      assign bus.rd_valid = vld_p1;
    end else begin : g_no_out_reg
      assign bus.rd_data  = data_p0;
      assign bus.rd_valid = vld_p0;
    end
  endgenerate

endmodule
